pio_irq_sequencer: RTL

Avalon-MM master that owns a 4-bit input PIO slave: data register at address 0, interrupt-mask register at address 2, registered readdata with 1-cycle latency. After reset it programs the PIO interrupt mask. It then samples the input port on every PIO irq rising edge and on a periodic poll timer. It turns level changes into rise/fall event words, queued in a small FIFO for the Nios-side or hardware consumer. It sits between the custom PIO and the game-control logic in the Qsys system.

---
 rtl/pio_seq_pkg.sv | 32 +++
 rtl/pio_event_fifo.sv | 56 +++++
 rtl/pio_irq_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pio_seq_pkg.sv
// rtl/pio_seq_pkg.sv - shared types and constants for the PIO irq sequencer
package pio_seq_pkg;

    typedef enum logic [2:0] {
        INIT_WR,
        IDLE,
        WR_MASK,
        RD_ADDR,
        RD_CAPT
    } state_t;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;

    localparam int EVT_LVL_LSB  = 8;
    localparam int EVT_RISE_LSB = 4;
    localparam int EVT_FALL_LSB = 0;
    localparam int EVT_W        = 12;

    // Packs one level-change event into the consumer-visible word.
    function automatic logic [EVT_W-1:0] make_evt(input logic [3:0] lvl,
                                                  input logic [3:0] rise,
                                                  input logic [3:0] fall);
        logic [EVT_W-1:0] w;
        w = '0;
        w[EVT_LVL_LSB  +: 4] = lvl;
        w[EVT_RISE_LSB +: 4] = rise;
        w[EVT_FALL_LSB +: 4] = fall;
        return w;
    endfunction

endpackage

// File: rtl/pio_event_fifo.sv
// rtl/pio_event_fifo.sv - small synchronous event FIFO with count/full/empty
module pio_event_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign do_push  = push && (!full || do_pop);
    // Head is masked while empty so stale storage never shows on the output.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pio_irq_sequencer.sv
// rtl/pio_irq_sequencer.sv - Avalon-MM master turning PIO input changes into queued events
module pio_irq_sequencer
    import pio_seq_pkg::*;
#(
    parameter logic [3:0]  MASK_INIT   = 4'hF,
    parameter logic [15:0] POLL_CYCLES = 16'd1000,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        pio_irq,
    input  logic        cfg_valid,
    input  logic [3:0]  cfg_mask,
    output logic        cfg_ready,
    output logic        evt_valid,
    output logic [11:0] evt_data,
    input  logic        evt_ready,
    output logic        overflow,
    input  logic        ovf_clr,
    output logic [3:0]  cur_mask
);

    localparam logic [15:0] POLL_LOAD = POLL_CYCLES - 16'd1;
    localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;

    state_t      state;
    state_t      next_state;
    logic        boot;
    logic        irq_q;
    logic        pend;
    logic [15:0] poll_cnt;
    logic [3:0]  prev;

    logic        irq_edge;
    logic        poll_hit;
    logic        serve_irq;

    logic [1:0]  nxt_address;
    logic        nxt_chipselect;
    logic        nxt_write_n;
    logic [31:0] nxt_writedata;
    logic        nxt_load_mask;
    logic [3:0]  nxt_mask;

    logic [3:0]  lvl;
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic        unused_readdata_hi;

    assign unused_readdata_hi = ^avm_readdata[31:4];

    assign cfg_ready = (state == IDLE);
    assign irq_edge  = pio_irq && !irq_q;
    assign poll_hit  = (POLL_CYCLES != 16'd0) && (poll_cnt == 16'd0);
    // An irq edge (fresh or remembered) is acted on only when no cfg outranks it.
    assign serve_irq = (state == IDLE) && !cfg_valid && (irq_edge || pend);

    assign lvl  = avm_readdata[3:0];
    assign rise = lvl & ~prev;
    assign fall = ~lvl & prev;
    assign push = (state == RD_CAPT) && ((rise | fall) != 4'd0);
    assign pop  = evt_ready && !fifo_empty;

    assign evt_valid = (fifo_count != '0);

    // State register; boot holds INIT_WR for the first post-reset edge so the write is launched then.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT_WR;
            boot  <= 1'b1;
        end else begin
            state <= next_state;
            boot  <= 1'b0;
        end
    end

    // Next-state selection and the bus values that go with the state being entered.
    always_comb begin
        next_state     = state;
        nxt_address    = ADDR_DATA;
        nxt_chipselect = 1'b0;
        nxt_write_n    = 1'b1;
        nxt_writedata  = 32'd0;
        nxt_load_mask  = 1'b0;
        nxt_mask       = cur_mask;

        case (state)
            INIT_WR: next_state = boot ? INIT_WR : IDLE;
            IDLE: begin
                if (cfg_valid)                  next_state = WR_MASK;
                else if (irq_edge || pend)      next_state = RD_ADDR;
                else if (poll_hit)              next_state = RD_ADDR;
            end
            WR_MASK: next_state = IDLE;
            RD_ADDR: next_state = RD_CAPT;
            RD_CAPT: next_state = IDLE;
            default: next_state = INIT_WR;
        endcase

        case (next_state)
            INIT_WR: begin
                nxt_address    = ADDR_MASK;
                nxt_chipselect = 1'b1;
                nxt_write_n    = 1'b0;
                nxt_writedata  = {28'd0, MASK_INIT};
                nxt_load_mask  = 1'b1;
                nxt_mask       = MASK_INIT;
            end
            WR_MASK: begin
                nxt_address    = ADDR_MASK;
                nxt_chipselect = 1'b1;
                nxt_write_n    = 1'b0;
                nxt_writedata  = {28'd0, cfg_mask};
                nxt_load_mask  = 1'b1;
                nxt_mask       = cfg_mask;
            end
            // The read select stays up through RD_CAPT; the PIO read is side-effect free.
            RD_ADDR, RD_CAPT: begin
                nxt_address    = ADDR_DATA;
                nxt_chipselect = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered bus outputs and the mirrored mask, so they sit at reset values during reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avm_address    <= ADDR_DATA;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= 32'd0;
            cur_mask       <= 4'd0;
        end else begin
            avm_address    <= nxt_address;
            avm_chipselect <= nxt_chipselect;
            avm_write_n    <= nxt_write_n;
            avm_writedata  <= nxt_writedata;
            if (nxt_load_mask) cur_mask <= nxt_mask;
        end
    end

    // Irq edge detection and the pending flag for edges that could not be served at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
            pend  <= 1'b0;
        end else begin
            irq_q <= pio_irq;
            if (irq_edge && !serve_irq) pend <= 1'b1;
            else if (serve_irq)         pend <= 1'b0;
        end
    end

    // Poll timer: reload on every read, count down only while idle, stop at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_cnt <= POLL_LOAD;
        end else if (next_state == RD_ADDR && state != RD_ADDR) begin
            poll_cnt <= POLL_LOAD;
        end else if (state == IDLE && poll_cnt != 16'd0) begin
            poll_cnt <= poll_cnt - 16'd1;
        end
    end

    // Last captured level, updated on every capture even when the event is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= 4'd0;
        end else if (state == RD_CAPT) begin
            prev <= lvl;
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    pio_event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (make_evt(lvl, rise, fall)),
        .pop       (pop),
        .pop_data  (evt_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
